div_arbiter: RTL

//   Shares one iterative integer divider (div_int) between NUM_REQ requesters.

---
 rtl/div_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative div_int among NUM_REQ requesters; one op in flight.
// Response WIDTH+3 cycles after accept (3 on divide-by-zero); a stalled response blocks all new accepts.
module div_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
  output logic                     rsp_dbz,
  output logic [ID_W-1:0]          grant_id,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_x,
  output logic [WIDTH-1:0]         div_y,
  input  logic                     div_busy,
  input  logic                     div_valid,
  input  logic                     div_dbz,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q;
  logic [ID_W-1:0]      rr_q;
  logic [ID_W-1:0]      grant_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     r_q;
  logic                 dbz_q;
  logic                 start_q;
  logic [NUM_REQ-1:0]   rsp_vld_q;

  logic                 win_vld;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;

  function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rot(rr_q, k);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_vld) req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
      start_q   <= 1'b0;
      rsp_vld_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            x_q     <= req_x[win_id*WIDTH +: WIDTH];
            y_q     <= req_y[win_id*WIDTH +: WIDTH];
            grant_q <= win_id;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          // dbz wins over a simultaneous valid so a zero divisor never leaks a result.
          if (div_dbz) begin
            q_q       <= '0;
            r_q       <= '0;
            dbz_q     <= 1'b1;
            rsp_vld_q <= NUM_REQ'(1) << grant_q;
            state_q   <= RESP;
          end else if (!div_busy && div_valid) begin
            q_q       <= div_q;
            r_q       <= div_r;
            dbz_q     <= 1'b0;
            rsp_vld_q <= NUM_REQ'(1) << grant_q;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_vld_q <= '0;
            rr_q      <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_q     = q_q;
  assign rsp_r     = r_q;
  assign rsp_dbz   = dbz_q;
  assign grant_id  = grant_q;
  assign div_start = start_q;
  assign div_x     = x_q;
  assign div_y     = y_q;

endmodule
